// File: rtl/sim_test_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_test_mailbox_pkg
// Purpose  : Shared constants for the simulation test mailbox: bus accept
//            order code, per-channel register offsets, global FSM encoding
//            and the bus byte-swap helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sim_test_mailbox_pkg;

  // Memory-bus order code that qualifies a mailbox write
  localparam logic [1:0] ORDER_WRITE = 2'h2;

  // Byte offsets inside one 0x20-byte channel window
  localparam logic [4:0] OFF_FLAG   = 5'h00;
  localparam logic [4:0] OFF_FINISH = 5'h04;
  localparam logic [4:0] OFF_LOG    = 5'h08;
  localparam logic [4:0] OFF_TYPE   = 5'h0C;
  localparam logic [4:0] OFF_INDEX  = 5'h10;
  localparam logic [4:0] OFF_RESULT = 5'h14;
  localparam logic [4:0] OFF_EXPECT = 5'h18;

  // Upper bound on channel count; per-channel storage is sized to this
  localparam int CH_MAX = 8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_TOUT = 2'd2
  } state_t;

  // The snooped bus carries data big-endian; registers hold it little-endian
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sim_test_mailbox_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sim_test_mailbox_fifo
// Purpose  : Log FIFO with first-word-fall-through head, sticky overflow flag
//            and simultaneous push/pop support when full.
// Ports    : clk, rst_n (async active-low)
//            push, push_data  - write side; dropped when full unless popping
//            pop              - read side; ignored when empty
//            valid, head      - not-empty flag and current head entry
//            ovf              - sticky overflow indication
// Revision : 1.0 - initial release
// ============================================================================
module sim_test_mailbox_fifo #(
  parameter int P_DEPTH = 8,
  parameter int P_WIDTH = 35
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [P_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic               valid,
  output logic [P_WIDTH-1:0] head,
  output logic               ovf
);

  localparam int AW = $clog2(P_DEPTH);

  // Pointers carry one wrap bit above the index so full and empty differ
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic               empty;
  logic               full;
  logic               do_pop;
  logic               do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO succeeds
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  // Storage needs no reset: it is only observed through the non-empty gate
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign valid = !empty;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/sim_test_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : sim_test_mailbox
// Purpose  : Snoops memory-bus writes into per-channel test-result mailboxes,
//            tracks completion of all channels, latches the first failure
//            record and buffers log words in a FIFO.
// Ports    : iCLOCK, inRESET (async active-low)
//            iMEMORY_*         - snooped bus request/lock/rw/order/addr/data
//            oFINISH, oPASS    - run complete, overall result
//            oTIMEOUT          - watchdog expiry (sticky)
//            oERR_*            - first failing channel's record
//            iLOG_RD, oLOG_*   - log FIFO pop port and head view
// Config   : MIST1032ISA_MAILBOX_TIMEOUT_EN enables the RUN-state watchdog;
//            without it oTIMEOUT is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module sim_test_mailbox
  import sim_test_mailbox_pkg::*;
#(
  parameter logic [31:0] P_BASE_ADDR = 32'h0002_0000,
  parameter int          P_CH_N      = 2,
  parameter int          P_LOG_DEPTH = 8,
  parameter int          P_TIMEOUT   = 750000
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  input  logic        iMEMORY_RW,
  input  logic [1:0]  iMEMORY_ORDER,
  input  logic [31:0] iMEMORY_ADDR,
  input  logic [31:0] iMEMORY_DATA,
  output logic        oFINISH,
  output logic        oPASS,
  output logic        oTIMEOUT,
  output logic [2:0]  oERR_CH,
  output logic [31:0] oERR_TYPE,
  output logic [31:0] oERR_INDEX,
  output logic [31:0] oERR_RESULT,
  output logic [31:0] oERR_EXPECT,
  input  logic        iLOG_RD,
  output logic        oLOG_VALID,
  output logic [2:0]  oLOG_CH,
  output logic [31:0] oLOG_DATA,
  output logic        oLOG_OVF
);

  localparam logic [31:0] CH_SPAN = 32'(P_CH_N) << 5;
  localparam logic [7:0]  CH_MASK = 8'((1 << P_CH_N) - 1);

  logic        accept;
  logic        hit;
  logic        reg_wr;
  logic        push_log;
  logic [31:0] off;
  logic [31:0] value;
  logic [2:0]  ch;
  logic [4:0]  reg_off;

  logic [7:0]  flag;
  logic [7:0]  done;
  logic [31:0] typ_r [CH_MAX];
  logic [31:0] idx_r [CH_MAX];
  logic [31:0] res_r [CH_MAX];
  logic [31:0] exp_r [CH_MAX];

  logic        err_valid;
  logic [2:0]  err_ch;
  logic [31:0] err_type;
  logic [31:0] err_index;
  logic [31:0] err_result;
  logic [31:0] err_expect;

  logic        all_done;
  logic        wd_expire;
  state_t      state;
  state_t      state_nx;
  logic [34:0] log_head;

  // Address decode: an address below the base wraps to a huge offset and misses
  assign accept   = iMEMORY_REQ && !iMEMORY_LOCK && (iMEMORY_ORDER == ORDER_WRITE) && iMEMORY_RW;
  assign off      = iMEMORY_ADDR - P_BASE_ADDR;
  assign hit      = accept && (off < CH_SPAN);
  assign ch       = off[7:5];
  assign reg_off  = off[4:0];
  assign value    = byte_swap(iMEMORY_DATA);
  // A finished channel is frozen except for its log port
  assign reg_wr   = hit && !done[ch];
  assign push_log = hit && (reg_off == OFF_LOG);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      flag       <= '0;
      done       <= '0;
      err_valid  <= 1'b0;
      err_ch     <= '0;
      err_type   <= '0;
      err_index  <= '0;
      err_result <= '0;
      err_expect <= '0;
      for (int i = 0; i < CH_MAX; i++) begin
        typ_r[i] <= '0;
        idx_r[i] <= '0;
        res_r[i] <= '0;
        exp_r[i] <= '0;
      end
    end else if (reg_wr) begin
      case (reg_off)
        OFF_FLAG:   flag[ch]  <= value[0];
        OFF_TYPE:   typ_r[ch] <= value;
        OFF_INDEX:  idx_r[ch] <= value;
        OFF_RESULT: res_r[ch] <= value;
        OFF_EXPECT: exp_r[ch] <= value;
        OFF_FINISH: begin
          done[ch] <= 1'b1;
          // Only the first failing channel's record is kept
          if (!flag[ch] && !err_valid) begin
            err_valid  <= 1'b1;
            err_ch     <= ch;
            err_type   <= typ_r[ch];
            err_index  <= idx_r[ch];
            err_result <= res_r[ch];
            err_expect <= exp_r[ch];
          end
        end
        default: ;
      endcase
    end
  end

  assign all_done = ((done & CH_MASK) == CH_MASK);

`ifdef MIST1032ISA_MAILBOX_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(P_TIMEOUT - 1);
  logic [31:0] wd_cnt;

  // Counts idle RUN cycles; any mailbox write restarts the window
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)                     wd_cnt <= '0;
    else if (hit || state != ST_RUN)  wd_cnt <= '0;
    else                              wd_cnt <= wd_cnt + 32'd1;
  end

  assign wd_expire = (state == ST_RUN) && !hit && (wd_cnt == WD_LAST);
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= ST_RUN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    oFINISH  = 1'b0;
    oPASS    = 1'b0;
    oTIMEOUT = 1'b0;
    case (state)
      ST_RUN: begin
        if (all_done)       state_nx = ST_DONE;
        else if (wd_expire) state_nx = ST_TOUT;
      end
      ST_DONE: begin
        oFINISH = 1'b1;
        oPASS   = !err_valid;
      end
      ST_TOUT: begin
        oFINISH = 1'b1;
`ifdef MIST1032ISA_MAILBOX_TIMEOUT_EN
        oTIMEOUT = 1'b1;
`endif
      end
      default: state_nx = ST_RUN;
    endcase
  end

  assign oERR_CH     = err_ch;
  assign oERR_TYPE   = err_type;
  assign oERR_INDEX  = err_index;
  assign oERR_RESULT = err_result;
  assign oERR_EXPECT = err_expect;

  sim_test_mailbox_fifo #(
    .P_DEPTH (P_LOG_DEPTH),
    .P_WIDTH (35)
  ) u_log_fifo (
    .clk       (iCLOCK),
    .rst_n     (inRESET),
    .push      (push_log),
    .push_data ({ch, value}),
    .pop       (iLOG_RD),
    .valid     (oLOG_VALID),
    .head      (log_head),
    .ovf       (oLOG_OVF)
  );

  assign oLOG_CH   = log_head[34:32];
  assign oLOG_DATA = log_head[31:0];

endmodule
`default_nettype wire
